esc_pwm_bank: RTL and testbench

ESC_PWM_BANK -- requirements
Module: esc_pwm_bank

---
 rtl/esc_pwm_bank.sv | 154 +++++++++++++++
 tb/tb_esc_pwm_bank.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_pwm_bank.sv
// -----------------------------------------------------------------------------
// esc_pwm_bank
//
// Four-channel ESC (electronic speed controller) pulse generator. A free-running
// frame counter defines a fixed PWM frame. Each channel emits one pulse per
// frame, starting at cnt = 0, whose width is BASE + 3*speed clock cycles. New
// speeds are written with a single-cycle strobe into shadow registers. They
// take effect only at the next frame boundary, so a pulse already in progress
// is never cut short or stretched. A watchdog forces all channels to the
// speed-0 width (failsafe) after WDOG_FRAMES frames without a write.
//
// Parameters:
//   PERIOD       frame length in clk cycles (must exceed BASE + 6141)
//   BASE         pulse width in clk cycles for speed 0
//   WDOG_FRAMES  consecutive write-less frames before failsafe
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   wrt          single-cycle strobe; the four speed inputs are valid
//   frnt_spd, bck_spd, lft_spd, rght_spd   11-bit unsigned speed commands
//   frnt, bck, lft, rght                   PWM outputs (registered)
//   frame_done   high on the last cycle of every frame (registered)
//   failsafe     high while in FAILSAFE (registered)
// -----------------------------------------------------------------------------
module esc_pwm_bank #(
  parameter int PERIOD      = 1048576,
  parameter int BASE        = 50000,
  parameter int WDOG_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        frnt,
  output logic        bck,
  output logic        lft,
  output logic        rght,
  output logic        frame_done,
  output logic        failsafe
);

  localparam int              CW       = $clog2(PERIOD);
  localparam int              DW       = $clog2(WDOG_FRAMES + 1);
  localparam logic [CW-1:0]   LAST     = CW'(PERIOD - 1);
  localparam logic [15:0]     BASE_W   = 16'(BASE);
  localparam logic [DW-1:0]   WDOG_MAX = DW'(WDOG_FRAMES);

  typedef enum logic [1:0] {IDLE, RUN, FAILSAFE} state_t;

  // Channel index 0..3 = frnt, bck, lft, rght.
  typedef logic [3:0][10:0] spd_vec_t;
  typedef logic [3:0][15:0] width_vec_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [DW-1:0]    wdog, wdog_nxt;
  spd_vec_t         shadow, spd_in, spd_src;
  width_vec_t       width, width_nxt;
  logic             wrt_seen;   // a wrt has occurred earlier in this frame
  logic             frame_wrt;  // a wrt occurred anywhere in this frame, incl. now
  logic             boundary;
  logic [3:0]       pwm, pwm_nxt;

  function automatic logic [15:0] speed_to_width(input logic [10:0] spd);
    return BASE_W + ({5'd0, spd} * 16'd3);
  endfunction

  assign spd_in    = {rght_spd, lft_spd, bck_spd, frnt_spd};
  assign boundary  = (cnt == LAST);
  assign cnt_nxt   = boundary ? '0 : cnt + CW'(1);
  assign frame_wrt = wrt_seen | wrt;
  // A write on the boundary cycle itself feeds the new frame directly.
  assign spd_src   = wrt ? spd_in : shadow;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    width_nxt = width;
    if (boundary) begin
      unique case (state)
        IDLE: begin
          if (frame_wrt) state_nxt = RUN;
        end
        RUN: begin
          if (frame_wrt) begin
            wdog_nxt = '0;
          end else begin
            wdog_nxt = wdog + DW'(1);
            if (wdog_nxt >= WDOG_MAX) state_nxt = FAILSAFE;
          end
        end
        FAILSAFE: begin
          if (frame_wrt) begin
            state_nxt = RUN;
            wdog_nxt  = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
      for (int c = 0; c < 4; c++) begin
        width_nxt[c] = (state_nxt == FAILSAFE) ? BASE_W : speed_to_width(spd_src[c]);
      end
    end
  end

  // Outputs are registered, so they are computed from the counter and widths
  // that the next cycle will hold; this keeps each pulse aligned to cnt = 0.
  always_comb begin
    pwm_nxt = '0;
    for (int c = 0; c < 4; c++) begin
      pwm_nxt[c] = (state_nxt != IDLE) && (32'(cnt_nxt) < 32'(width_nxt[c]));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge regardless of statement order.
  // NOTE: shadow and width are only a few flops, so they are reset with the
  // rest of the state rather than treated as an unreset storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      state      <= IDLE;
      wdog       <= '0;
      shadow     <= '0;
      width      <= '0;
      wrt_seen   <= 1'b0;
      pwm        <= '0;
      frame_done <= 1'b0;
      failsafe   <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      state      <= state_nxt;
      wdog       <= wdog_nxt;
      width      <= width_nxt;
      if (wrt) shadow <= spd_in;
      wrt_seen   <= boundary ? 1'b0 : frame_wrt;
      pwm        <= pwm_nxt;
      frame_done <= (cnt_nxt == LAST);
      failsafe   <= (state_nxt == FAILSAFE);
    end
  end

  assign frnt = pwm[0];
  assign bck  = pwm[1];
  assign lft  = pwm[2];
  assign rght = pwm[3];

endmodule

// File: tb/tb_esc_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_esc_pwm_bank
//
// Frame-level bench for esc_pwm_bank with PERIOD=8192, BASE=1000,
// WDOG_FRAMES=4. Each frame is stepped cycle by cycle; per channel the bench
// measures the pulse length and its first/last high cycle, plus the frame_done
// position and how many cycles failsafe was high. Expected widths come from
// literal values or from a frame-level model of the write/watchdog rules.
// -----------------------------------------------------------------------------
module tb_esc_pwm_bank;

  localparam int PERIOD = 8192;
  localparam int BASE   = 1000;
  localparam int WDOG   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        frnt, bck, lft, rght, frame_done, failsafe;

  always #5 clk = ~clk;

  esc_pwm_bank #(.PERIOD(PERIOD), .BASE(BASE), .WDOG_FRAMES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .frnt(frnt), .bck(bck), .lft(lft), .rght(rght),
    .frame_done(frame_done), .failsafe(failsafe)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef logic [3:0][10:0] spd_vec_t;
  typedef struct {
    int       at;
    spd_vec_t spd;
  } wr_t;

  wr_t sched[$];

  // Frame-level reference model: mode 0 = idle, 1 = run, 2 = failsafe.
  int          m_mode;
  int          m_empty;
  int          m_w[4];
  logic [10:0] m_shadow[4];
  bit          m_had_wrt;

  // Per-frame measurements.
  int exp_w[4];
  int meas_cnt[4], meas_first[4], meas_last[4];
  int fd_cnt, fd_pos, fs_high;

  function automatic logic [10:0] rnd_spd();
    return 11'($urandom_range(0, 2047));
  endfunction

  function automatic logic pwm_of(input int c);
    case (c)
      0:       return frnt;
      1:       return bck;
      2:       return lft;
      default: return rght;
    endcase
  endfunction

  task automatic schedule_write(input int at, input logic [10:0] f, b, l, r);
    wr_t w;
    w.at  = at;
    w.spd = {r, l, b, f};
    sched.push_back(w);
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_empty   = 0;
    m_had_wrt = 0;
    for (int c = 0; c < 4; c++) begin
      m_w[c]      = 0;
      m_shadow[c] = '0;
    end
  endtask

  task automatic model_boundary();
    if (m_mode == 0) begin
      if (m_had_wrt) m_mode = 1;
    end else if (m_mode == 1) begin
      m_empty = m_had_wrt ? 0 : m_empty + 1;
      if (m_empty >= WDOG) m_mode = 2;
    end else if (m_had_wrt) begin
      m_mode  = 1;
      m_empty = 0;
    end
    for (int c = 0; c < 4; c++) m_w[c] = (m_mode == 2) ? BASE : BASE + 3 * int'(m_shadow[c]);
    m_had_wrt = 0;
  endtask

  // Steps one whole frame starting at the negedge of its cnt = 0 cycle.
  task automatic run_frame();
    wr_t w;
    for (int c = 0; c < 4; c++) begin
      exp_w[c]      = (m_mode == 0) ? 0 : m_w[c];
      meas_cnt[c]   = 0;
      meas_first[c] = -1;
      meas_last[c]  = -1;
    end
    fd_cnt  = 0;
    fd_pos  = -1;
    fs_high = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (sched.size() > 0 && sched[0].at == k) begin
        w = sched.pop_front();
        frnt_spd = w.spd[0];
        bck_spd  = w.spd[1];
        lft_spd  = w.spd[2];
        rght_spd = w.spd[3];
        wrt      = 1'b1;
        for (int c = 0; c < 4; c++) m_shadow[c] = w.spd[c];
        m_had_wrt = 1;
      end else begin
        wrt = 1'b0;
      end
      for (int c = 0; c < 4; c++) begin
        if (pwm_of(c) === 1'b1) begin
          if (meas_first[c] < 0) meas_first[c] = k;
          meas_last[c] = k;
          meas_cnt[c]++;
        end
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_pos = k;
      end
      if (failsafe === 1'b1) fs_high++;
      @(negedge clk);
    end
    wrt = 1'b0;
    model_boundary();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wrt   = 1'b0;
    frnt_spd = '0; bck_spd = '0; lft_spd = '0; rght_spd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({frnt, bck, lft, rght, frame_done, failsafe} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {frnt, bck, lft, rght, frame_done, failsafe});
    end
    vectors++;
    if (int'(dut.cnt) !== 0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d, required 0", dut.cnt);
    end
    rst_n = 1'b1;
  endtask

  // Three frames with no write effect: outputs low, frame_done once per frame.
  // The write that starts the next scenario lands late in the third frame.
  task automatic test_idle();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) schedule_write(8000, 11'd0, 11'd100, 11'd1000, 11'd2047);
      run_frame();
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (meas_cnt[c] !== 0) begin
          miscompares++;
          $display("FAIL idle_f%0d ch%0d: high for %0d cycles, required 0", f, c, meas_cnt[c]);
        end
      end
      vectors++;
      if (fd_cnt !== 1 || fd_pos !== PERIOD - 1) begin
        miscompares++;
        $display("FAIL idle_f%0d frame_done: %0d pulses last at %0d, required 1 at %0d",
                 f, fd_cnt, fd_pos, PERIOD - 1);
      end
      vectors++;
      if (fs_high !== 0) begin
        miscompares++;
        $display("FAIL idle_f%0d failsafe: high %0d cycles, required 0", f, fs_high);
      end
    end
  endtask

  // Widths from the first write; two writes mid-frame must not disturb them.
  task automatic test_widths();
    int want[4];
    want = '{1000, 1300, 4000, 7141};
    schedule_write(500, 11'd10, rnd_spd(), rnd_spd(), rnd_spd());
    schedule_write(600, 11'd20, rnd_spd(), rnd_spd(), rnd_spd());
    run_frame();
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (meas_cnt[c] !== want[c] || meas_first[c] !== 0 || meas_last[c] !== want[c] - 1) begin
        miscompares++;
        $display("FAIL widths ch%0d: %0d cycles [%0d..%0d], required %0d from cnt 0",
                 c, meas_cnt[c], meas_first[c], meas_last[c], want[c]);
      end
    end
    vectors++;
    if (fd_cnt !== 1 || fd_pos !== PERIOD - 1 || fs_high !== 0) begin
      miscompares++;
      $display("FAIL widths frame: frame_done %0d at %0d, failsafe %0d cycles, required 1 at %0d, 0",
               fd_cnt, fd_pos, fs_high, PERIOD - 1);
    end
  endtask

  // Second of two writes wins; a write on the boundary cycle is queued next.
  task automatic test_last_write_wins();
    int want[4];
    schedule_write(PERIOD - 1, 11'd50, rnd_spd(), rnd_spd(), rnd_spd());
    run_frame();
    want = exp_w;
    want[0] = 1060;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (meas_cnt[c] !== want[c] || meas_first[c] !== 0 || meas_last[c] !== want[c] - 1) begin
        miscompares++;
        $display("FAIL last_write ch%0d: %0d cycles [%0d..%0d], required %0d from cnt 0",
                 c, meas_cnt[c], meas_first[c], meas_last[c], want[c]);
      end
    end
  endtask

  // Boundary-cycle write is used by the very next frame.
  task automatic test_boundary_bypass();
    int want[4];
    run_frame();
    want = exp_w;
    want[0] = 1150;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (meas_cnt[c] !== want[c] || meas_first[c] !== 0 || meas_last[c] !== want[c] - 1) begin
        miscompares++;
        $display("FAIL bypass ch%0d: %0d cycles [%0d..%0d], required %0d from cnt 0",
                 c, meas_cnt[c], meas_first[c], meas_last[c], want[c]);
      end
    end
    vectors++;
    if (fs_high !== 0) begin
      miscompares++;
      $display("FAIL bypass failsafe: high %0d cycles, required 0", fs_high);
    end
  endtask

  // Three more empty frames keep the old widths; the fourth runs in failsafe.
  task automatic test_watchdog();
    int want[4];
    int want_fs;
    for (int f = 0; f < 4; f++) begin
      if (f == 3) schedule_write(7000, 11'd200, 11'd200, 11'd200, 11'd200);
      run_frame();
      for (int c = 0; c < 4; c++) want[c] = (f == 3) ? 1000 : exp_w[c];
      want_fs = (f == 3) ? PERIOD : 0;
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (meas_cnt[c] !== want[c] || meas_first[c] !== 0 || meas_last[c] !== want[c] - 1) begin
          miscompares++;
          $display("FAIL watchdog_f%0d ch%0d: %0d cycles [%0d..%0d], required %0d from cnt 0",
                   f, c, meas_cnt[c], meas_first[c], meas_last[c], want[c]);
        end
      end
      vectors++;
      if (fs_high !== want_fs) begin
        miscompares++;
        $display("FAIL watchdog_f%0d failsafe: high %0d cycles, required %0d", f, fs_high, want_fs);
      end
    end
  endtask

  // One write in failsafe restores RUN with the written speeds.
  task automatic test_recovery();
    run_frame();
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (meas_cnt[c] !== 1600 || meas_first[c] !== 0 || meas_last[c] !== 1599) begin
        miscompares++;
        $display("FAIL recovery ch%0d: %0d cycles [%0d..%0d], required 1600 from cnt 0",
                 c, meas_cnt[c], meas_first[c], meas_last[c]);
      end
    end
    vectors++;
    if (fs_high !== 0 || fd_cnt !== 1 || fd_pos !== PERIOD - 1) begin
      miscompares++;
      $display("FAIL recovery frame: failsafe %0d cycles, frame_done %0d at %0d, required 0, 1 at %0d",
               fs_high, fd_cnt, fd_pos, PERIOD - 1);
    end
  endtask

  // Reset asserted in the middle of a pulse drops outputs immediately.
  task automatic test_reset_mid_pulse();
    int bad;
    repeat (500) @(negedge clk);
    vectors++;
    if (frnt !== 1'b1 || int'(dut.cnt) !== 500) begin
      miscompares++;
      $display("FAIL mid_pulse_pre: frnt %b cnt %0d, required 1 at 500", frnt, dut.cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({frnt, bck, lft, rght, frame_done, failsafe} !== 6'b0) begin
      miscompares++;
      $display("FAIL mid_pulse_drop: got %b, required 000000",
               {frnt, bck, lft, rght, frame_done, failsafe});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (int'(dut.cnt) !== k || {frnt, bck, lft, rght, frame_done, failsafe} !== 6'b0) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL post_reset_restart: %0d bad cycles of 50, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_widths();
    test_last_write_wins();
    test_boundary_bypass();
    test_watchdog();
    test_recovery();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
